// File: rtl/number_display_sequencer.sv
// LCD feeder: runs the LCD power-up command sequence, then sends a 6-word frame
// (set-address + 5 characters) showing `number` in decimal or binary whenever the inputs change.
module number_display_sequencer #(
  parameter int          ACK_TIMEOUT = 15,
  parameter logic [7:0]  LINE_ADDR   = 8'h80
) (
  input  logic       clock,
  input  logic       internal_reset,
  input  logic [4:0] number,
  input  logic       control,
  input  logic       lcd_busy,
  output logic [8:0] d_in,
  output logic       data_ready,
  output logic       seq_busy
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, FRM_ISSUE, FRM_WAIT} state_t;

  state_t          r_state, w_nxt_state;
  logic [2:0]      r_idx, w_nxt_idx;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            r_rise, w_nxt_rise;
  logic [4:0]      r_num_s1, r_num_s2;
  logic            r_ctl_s1, r_ctl_s2;
  logic [5:0]      r_last, r_frame;
  logic [8:0]      r_d_in;
  logic            r_dr;

  logic [5:0]      w_key;
  logic            w_load, w_snap, w_accept, w_last_word;
  logic [8:0]      w_init_word, w_frm_word, w_issue_word;
  logic [4:0]      w_n;
  logic [1:0]      w_tens;
  logic [3:0]      w_units;

  assign w_key      = {r_ctl_s2, r_num_s2};
  assign d_in       = r_d_in;
  assign data_ready = r_dr;
  assign seq_busy   = (r_state != IDLE);

  always_comb begin
    case (r_idx)
      3'd0:    w_init_word = 9'h038;
      3'd1:    w_init_word = 9'h00C;
      3'd2:    w_init_word = 9'h001;
      default: w_init_word = 9'h006;
    endcase
  end

  // Frame words come only from the snapshot, so input changes mid-frame cannot tear it.
  always_comb begin
    w_n = r_frame[4:0];
    if (w_n >= 5'd30)      w_tens = 2'd3;
    else if (w_n >= 5'd20) w_tens = 2'd2;
    else if (w_n >= 5'd10) w_tens = 2'd1;
    else                   w_tens = 2'd0;
    w_units    = 4'(w_n - 5'(w_tens) * 5'd10);
    w_frm_word = 9'h120;
    case (r_idx)
      3'd0: w_frm_word = {1'b0, LINE_ADDR};
      3'd1: w_frm_word = r_frame[5] ? {1'b1, 7'h18, w_n[4]} : {1'b1, 6'h0C, w_tens};
      3'd2: w_frm_word = r_frame[5] ? {1'b1, 7'h18, w_n[3]} : {1'b1, 4'h3, w_units};
      3'd3: w_frm_word = r_frame[5] ? {1'b1, 7'h18, w_n[2]} : 9'h120;
      3'd4: w_frm_word = r_frame[5] ? {1'b1, 7'h18, w_n[1]} : 9'h120;
      3'd5: w_frm_word = r_frame[5] ? {1'b1, 7'h18, w_n[0]} : 9'h120;
      default: w_frm_word = 9'h120;
    endcase
    w_issue_word = (r_state == INIT_ISSUE) ? w_init_word : w_frm_word;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_nxt_rise  = r_rise;
    w_load      = 1'b0;
    w_snap      = 1'b0;
    w_accept    = 1'b0;
    w_last_word = (r_state == INIT_WAIT) ? (r_idx == 3'd3) : (r_idx == 3'd5);
    case (r_state)
      INIT_ISSUE, FRM_ISSUE: begin
        if (!lcd_busy) begin
          w_load      = 1'b1;
          w_nxt_cnt   = '0;
          w_nxt_rise  = 1'b0;
          w_nxt_state = (r_state == INIT_ISSUE) ? INIT_WAIT : FRM_WAIT;
        end
      end
      INIT_WAIT, FRM_WAIT: begin
        // A driver that never raises busy still lets the sequence advance after the timeout.
        if (!r_rise) begin
          if (lcd_busy)                              w_nxt_rise = 1'b1;
          else if (r_cnt == CW'(ACK_TIMEOUT - 1))    w_accept   = 1'b1;
          else                                       w_nxt_cnt  = r_cnt + 1'b1;
        end else if (!lcd_busy) begin
          w_accept = 1'b1;
        end
        if (w_accept) begin
          if (w_last_word) begin
            w_nxt_idx   = '0;
            w_nxt_state = IDLE;
          end else begin
            w_nxt_idx   = r_idx + 3'd1;
            w_nxt_state = (r_state == INIT_WAIT) ? INIT_ISSUE : FRM_ISSUE;
          end
        end
      end
      IDLE: begin
        if (w_key != r_last) begin
          w_snap      = 1'b1;
          w_nxt_idx   = '0;
          w_nxt_state = FRM_ISSUE;
        end
      end
      default: w_nxt_state = INIT_ISSUE;
    endcase
  end

  always_ff @(posedge clock or negedge internal_reset) begin
    if (!internal_reset) begin
      r_state  <= INIT_ISSUE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_num_s1 <= '0;
      r_num_s2 <= '0;
      r_ctl_s1 <= 1'b0;
      r_ctl_s2 <= 1'b0;
      r_last   <= 6'h3F;
      r_frame  <= '0;
      r_d_in   <= '0;
      r_dr     <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_idx    <= w_nxt_idx;
      r_cnt    <= w_nxt_cnt;
      r_rise   <= w_nxt_rise;
      r_num_s1 <= number;
      r_num_s2 <= r_num_s1;
      r_ctl_s1 <= control;
      r_ctl_s2 <= r_ctl_s1;
      r_dr     <= w_load;
      if (w_load) r_d_in <= w_issue_word;
      if (w_snap) begin
        r_frame <= w_key;
        r_last  <= w_key;
      end
    end
  end

endmodule

// File: tb/tb_number_display_sequencer.sv
// Bench for number_display_sequencer: table vectors, random keys against an arithmetic
// frame model, and hand sequences for timeout, stall, mid-frame change and mid-frame reset.
module tb_number_display_sequencer;

  logic       clock = 1'b0;
  logic       internal_reset;
  logic [4:0] number;
  logic       control;
  logic       lcd_busy;
  logic [8:0] d_in;
  logic       data_ready;
  logic       seq_busy;

  number_display_sequencer #(.ACK_TIMEOUT(15), .LINE_ADDR(8'h80)) dut (
    .clock(clock), .internal_reset(internal_reset), .number(number), .control(control),
    .lcd_busy(lcd_busy), .d_in(d_in), .data_ready(data_ready), .seq_busy(seq_busy)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // LCD model: 0 = fixed 3-cycle busy, 1 = never busy, 2 = random 1..5 busy
  int   lcd_mode = 0;
  int   busy_cnt = 0;
  logic model_busy = 1'b0;
  logic hog = 1'b0;
  assign lcd_busy = model_busy | hog;

  int         cyc = 0;
  logic [8:0] got[$];
  int         got_cyc[$];
  logic       prev_dr = 1'b0;
  int         dr_err = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (data_ready) begin
      got.push_back(d_in);
      got_cyc.push_back(cyc);
      if (prev_dr) dr_err++;
    end
    prev_dr = data_ready;
    if (data_ready && lcd_mode != 1) begin
      busy_cnt   = (lcd_mode == 2) ? int'($urandom_range(1, 5)) : 3;
      model_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      model_busy = (busy_cnt > 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame from the display rules using plain arithmetic.
  function automatic logic [5:0][8:0] ref_frame(input int n, input bit c);
    logic [5:0][8:0] w;
    w[0] = 9'h080;
    if (c) begin
      for (int i = 1; i <= 5; i++) w[i] = {1'b1, 8'(8'h30 + ((n >> (5 - i)) & 1))};
    end else begin
      w[1] = {1'b1, 8'(8'h30 + n / 10)};
      w[2] = {1'b1, 8'(8'h30 + n % 10)};
      w[3] = 9'h120; w[4] = 9'h120; w[5] = 9'h120;
    end
    return w;
  endfunction

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin @(negedge clock); k++; end
    if (got.size() < n) chk({tag, "_timeout"}, got.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    @(negedge clock);
    while (seq_busy && k < budget) begin @(negedge clock); k++; end
    chk({tag, "_seq_busy_idle"}, seq_busy, 1'b0);
  endtask

  task automatic chk_word(input int idx, input logic [8:0] exp, input string tag);
    if (idx < got.size()) chk($sformatf("%s_w%0d", tag, idx), got[idx], exp);
    else                  chk($sformatf("%s_w%0d_missing", tag, idx), 32'hDEAD, exp);
  endtask

  task automatic chk_frame(input int base, input logic [5:0][8:0] exp, input string tag);
    for (int i = 0; i < 6; i++) chk_word(base + i, exp[i], tag);
  endtask

  task automatic chk_init(input string tag);
    chk_word(0, 9'h038, tag); chk_word(1, 9'h00C, tag);
    chk_word(2, 9'h001, tag); chk_word(3, 9'h006, tag);
  endtask

  task automatic set_key(input int n, input bit c);
    @(negedge clock);
    got.delete(); got_cyc.delete();
    number  = 5'(n);
    control = c;
  endtask

  typedef struct packed {
    logic [4:0]      n;
    logic            c;
    logic [5:0][8:0] w;
  } vec_t;

  vec_t tbl [6];
  int   cur_n, cur_c;

  initial begin
    tbl[0] = '{n: 5'd27, c: 1'b0, w: {9'h120, 9'h120, 9'h120, 9'h137, 9'h132, 9'h080}};
    tbl[1] = '{n: 5'd22, c: 1'b1, w: {9'h130, 9'h131, 9'h131, 9'h130, 9'h131, 9'h080}};
    tbl[2] = '{n: 5'd31, c: 1'b0, w: {9'h120, 9'h120, 9'h120, 9'h131, 9'h133, 9'h080}};
    tbl[3] = '{n: 5'd10, c: 1'b0, w: {9'h120, 9'h120, 9'h120, 9'h130, 9'h131, 9'h080}};
    tbl[4] = '{n: 5'd9,  c: 1'b0, w: {9'h120, 9'h120, 9'h120, 9'h139, 9'h130, 9'h080}};
    tbl[5] = '{n: 5'd1,  c: 1'b1, w: {9'h131, 9'h130, 9'h130, 9'h130, 9'h130, 9'h080}};

    internal_reset = 1'b0;
    number = 5'd0;
    control = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_d_in", d_in, 9'h000);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_seq_busy", seq_busy, 1'b1);

    // Power-up sequence followed by the first frame for 0 decimal.
    internal_reset = 1'b1;
    wait_words(10, 400, "init");
    chk_init("init");
    chk_frame(4, {9'h120, 9'h120, 9'h120, 9'h130, 9'h130, 9'h080}, "init_frm");
    wait_idle(100, "init");
    repeat (40) @(negedge clock);
    chk("init_no_extra", got.size(), 10);
    cur_n = 0; cur_c = 0;

    foreach (tbl[v]) begin
      set_key(tbl[v].n, tbl[v].c);
      wait_words(6, 300, $sformatf("tbl%0d", v));
      chk_frame(0, tbl[v].w, $sformatf("tbl%0d", v));
      wait_idle(100, $sformatf("tbl%0d", v));
      cur_n = tbl[v].n; cur_c = tbl[v].c;
    end

    lcd_mode = 2;
    for (int r = 0; r < 16; r++) begin
      int n; bit c;
      n = $urandom_range(0, 31);
      c = 1'($urandom_range(0, 1));
      if (n == cur_n && c == cur_c) n = (n + 1) % 32;
      set_key(n, c);
      wait_words(6, 400, $sformatf("rnd%0d", r));
      chk_frame(0, ref_frame(n, c), $sformatf("rnd%0d", r));
      wait_idle(100, $sformatf("rnd%0d", r));
      cur_n = n; cur_c = c;
    end
    lcd_mode = 0;
    repeat (10) @(negedge clock);

    // Busy already high when the frame wants to issue: it must stall, then send everything.
    begin
      int n;
      n = (cur_n == 25 && cur_c == 1) ? 26 : 25;
      @(negedge clock);
      hog = 1'b1;
      set_key(n, 1'b1);
      repeat (30) @(negedge clock);
      chk("stall_no_strobe", got.size(), 0);
      chk("stall_seq_busy", seq_busy, 1'b1);
      hog = 1'b0;
      wait_words(6, 300, "stall");
      chk_frame(0, ref_frame(n, 1'b1), "stall");
      wait_idle(100, "stall");
      cur_n = n; cur_c = 1;
    end

    // Key changes mid-frame: frame 3 completes, 9 is dropped, 12 follows once.
    set_key(3, 1'b0);
    wait_words(2, 200, "chg_start");
    number = 5'd9;
    repeat (4) @(negedge clock);
    number = 5'd12;
    wait_words(12, 400, "chg");
    chk_frame(0, ref_frame(3, 1'b0), "chg_first");
    chk_frame(6, ref_frame(12, 1'b0), "chg_second");
    wait_idle(100, "chg");
    repeat (60) @(negedge clock);
    chk("chg_no_extra", got.size(), 12);
    cur_n = 12; cur_c = 0;

    // Driver never raises busy: every word advances on the timeout.
    lcd_mode = 1;
    @(negedge clock);
    internal_reset = 1'b0;
    got.delete(); got_cyc.delete();
    repeat (2) @(negedge clock);
    internal_reset = 1'b1;
    wait_words(10, 600, "tmo");
    chk_init("tmo");
    chk_frame(4, ref_frame(12, 1'b0), "tmo_frm");
    for (int i = 1; i < 10 && i < got_cyc.size(); i++)
      chk($sformatf("tmo_gap%0d_ge15", i), (got_cyc[i] - got_cyc[i-1]) >= 15, 1'b1);
    wait_idle(100, "tmo");
    lcd_mode = 0;

    // Reset while waiting on a frame word.
    set_key(17, 1'b0);
    wait_words(3, 300, "mrst");
    begin
      int k = 0;
      while (!data_ready && k < 100) begin @(negedge clock); k++; end
      chk("mrst_strobe_seen", data_ready, 1'b1);
    end
    internal_reset = 1'b0;
    #1;
    chk("mrst_data_ready", data_ready, 1'b0);
    chk("mrst_d_in", d_in, 9'h000);
    chk("mrst_seq_busy", seq_busy, 1'b1);
    repeat (3) @(negedge clock);
    got.delete(); got_cyc.delete();
    internal_reset = 1'b1;
    wait_words(10, 400, "mrst");
    chk_init("mrst");
    chk_frame(4, ref_frame(17, 1'b0), "mrst_frm");
    wait_idle(100, "mrst");

    chk("no_back_to_back_strobe", dr_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/number_display_sequencer.md
Name: number_display_sequencer

Overview:
- Upstream feeder for the LCD driver. Replaces the ROM/controller pair when a live number is shown.
- Takes the 5-bit `number` and `control` switches, runs the LCD power-up command sequence, then writes a 6-word frame whenever the inputs change.
- Each 9-bit output word is {rs, data[7:0]}. Words are passed one at a time over the data_ready / busy_flag handshake.

Parameters:
- ACK_TIMEOUT, 15: cycles to wait for `lcd_busy` to rise after a `data_ready` pulse; if it never rises, the word counts as accepted.
- LINE_ADDR, 8'h80: DDRAM set-address command that starts every frame.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- internal_reset  input  1  asynchronous, active-low reset.
- number  input  1x5  value to display (0..31); asynchronous to `clock`.
- control  input  1  display mode: 0 = decimal, 1 = binary; asynchronous to `clock`.
- lcd_busy  input  1  busy flag from the LCD driver; high while it processes a word.
- d_in  output  9  word to the LCD driver: bit8 = rs (0 command, 1 data), bits7:0 = data.
- data_ready  output  1  one-cycle strobe: `d_in` is valid.
- seq_busy  output  1  high from reset until a frame is complete; low only in IDLE.

Behaviour:
- Reset (internal_reset = 0, async): `d_in` = 9'h000, `data_ready` = 0, `seq_busy` = 1.
  - Synchronizers and counters clear to 0.
  - The last-shown register becomes 6'h3F, an invalid tag, so the first frame always fires.
- Input capture:
  - `number` and `control` pass through 2-flop synchronizers.
  - The synchronized pair {control, number} is the display key.
- States: INIT_ISSUE, INIT_WAIT, IDLE, FRM_ISSUE, FRM_WAIT.
- Issue/wait handshake, common to the *_ISSUE/*_WAIT pairs:
  - ISSUE: load `d_in` and pulse `data_ready` for exactly 1 cycle, only when `lcd_busy` = 0; otherwise stay in ISSUE. Then go to WAIT.
  - WAIT phase A: wait for `lcd_busy` = 1, counting cycles. If the count reaches ACK_TIMEOUT with no rise, the word is accepted.
  - WAIT phase B: after a rise, wait for `lcd_busy` = 0; that cycle the word is accepted.
  - `d_in` holds its value throughout WAIT.
  - On acceptance, advance the word index; go to the next ISSUE, or IDLE after the last word.
- Init sequence, after every reset, in order: 9'h038 (function set), 9'h00C (display on, cursor off), 9'h001 (clear), 9'h006 (entry mode). Then go to IDLE.
- IDLE:
  - `seq_busy` = 0.
  - If key != last-shown, snapshot the key into the frame register, set last-shown = key, and go to FRM_ISSUE with index 0.
  - The frame uses only the snapshot; input changes during a frame do not disturb it.
  - Changes during a frame are caught on return to IDLE. Only the latest key is shown; intermediate values are dropped.
- Frame: 6 words.
  - Word 0: {0, LINE_ADDR}.
  - Words 1..5 are data (rs = 1).
  - control = 0, decimal: tens digit, units digit, then three spaces (8'h20) to erase leftover binary characters.
    - tens = 3 if n >= 30, 2 if n >= 20, 1 if n >= 10, else 0; units = n - 10*tens.
    - Digit character = 8'h30 + value.
    - Leading zero is shown, e.g. "07".
  - control = 1, binary: number[4] down to number[0], each as 8'h30 or 8'h31.
- `lcd_busy` already high at ISSUE: stall with no strobe; no word is lost.
- Async reset mid-operation: outputs return to reset values at once; the init sequence restarts after release.
- Strobe count: exactly 4 at init and exactly 6 per frame; `data_ready` is never asserted for two consecutive cycles.

Test Plan:
- Reset release, number = 0, control = 0, LCD model with 3-cycle busy → strobes carry 038, 00C, 001, 006, 080, 130, 130, 120, 120, 120; then `seq_busy` = 0 and no further strobes.
- In IDLE, number = 5'd27, control = 0 → 080, 132, 137, 120, 120, 120.
- Set control = 1, number = 5'b10110 → 080, 131, 130, 131, 131, 130.
- LCD model never raises `lcd_busy` → each word advances 15 cycles after its strobe; the full 10-word sequence still completes in order.
- Change number 3→9→12 during a frame → current frame finishes unchanged; exactly one new frame follows showing "12"; no frame for 9.
- Assert reset while in FRM_WAIT → `data_ready` = 0 and `d_in` = 000 immediately; after release the first strobe is 038.
